// File: rtl/flash_tick_gen.sv
// ---------------------------------------------------------------------------
// flash_tick_gen
//
// Programmable enable-pulse generator for the flash LED-pattern block. It
// divides the system clock into a one-cycle strobe. The strobe period is one
// of four build-time presets, chosen by board switches. The switches also
// provide pause (run bit low) and single-step (rising edge of the step bit
// while paused).
//
// Build option:
//   FLASH_TICK_GEN_SYNC_EN  defined   -> i_sw goes through a 2-flop
//                                        synchronizer per bit (2 cycles of
//                                        switch-to-effect latency).
//                           undefined -> i_sw is used directly. Use this only
//                                        for simulation or for sources that
//                                        are already synchronous to clock.
//
// Parameters:
//   NB_COUNTER        width of the cycle counter and of the period presets
//   LIMIT_0..LIMIT_3  strobe period in clock cycles for select 00..11
//                     (legal range 2 .. 2^NB_COUNTER-1)
//
// Ports:
//   clock      in   system clock, all logic on its rising edge
//   i_reset    in   synchronous active-low reset
//   i_sw[3:0]  in   [0] run, [2:1] period select, [3] step
//   o_enable   out  registered one-cycle strobe (drives flash.i_enable)
//   o_running  out  registered copy of the effective run bit
//
// Switch handshake: there is none. i_sw is a level input, sampled every
// cycle. o_enable is a single-cycle qualifier with no ready/back-pressure;
// the consumer must act on it in the cycle it is high.
// ---------------------------------------------------------------------------
module flash_tick_gen #(
    parameter int unsigned            NB_COUNTER = 32,
    parameter logic [NB_COUNTER-1:0]  LIMIT_0    = NB_COUNTER'(8),
    parameter logic [NB_COUNTER-1:0]  LIMIT_1    = NB_COUNTER'(16),
    parameter logic [NB_COUNTER-1:0]  LIMIT_2    = NB_COUNTER'(32),
    parameter logic [NB_COUNTER-1:0]  LIMIT_3    = NB_COUNTER'(64)
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic [3:0] i_sw,
    output logic       o_enable,
    output logic       o_running
);

    // Operating mode is a pure decode of the effective run switch. It is not
    // a stored state: the counter and period registers carry all history.
    typedef enum logic {
        MODE_STOP = 1'b0,
        MODE_RUN  = 1'b1
    } mode_t;

    // -----------------------------------------------------------------------
    // Effective switch value
    // -----------------------------------------------------------------------
    logic [3:0] sw_r;

`ifdef FLASH_TICK_GEN_SYNC_EN
    // Two-flop synchronizer per bit. The flops clear on reset, so the block
    // sees "all switches off" for two cycles after reset is released.
    logic [3:0] sw_meta;
    logic [3:0] sw_sync;

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            sw_meta <= 4'b0000;
            sw_sync <= 4'b0000;
        end else begin
            sw_meta <= i_sw;
            sw_sync <= sw_meta;
        end
    end

    assign sw_r = sw_sync;
`else
    assign sw_r = i_sw;
`endif

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [NB_COUNTER-1:0] cnt;
    logic [NB_COUNTER-1:0] period_q;
    logic                  step_d;

    logic [NB_COUNTER-1:0] cnt_nxt;
    logic [NB_COUNTER-1:0] period_nxt;
    logic                  enable_nxt;

    // -----------------------------------------------------------------------
    // Decodes
    // -----------------------------------------------------------------------
    mode_t                 mode;
    logic                  step_rise;
    logic                  at_wrap;
    logic [NB_COUNTER-1:0] sel_limit;

    assign mode      = mode_t'(sw_r[0]);
    assign step_rise = sw_r[3] & ~step_d;

    // The wrap test is ">=" rather than "==": a period shortened while
    // paused can leave cnt already past the new terminal count, and that
    // case must wrap on the very next running cycle instead of rolling all
    // the way around the counter.
    assign at_wrap = (cnt >= (period_q - NB_COUNTER'(1)));

    always_comb begin
        sel_limit = LIMIT_0;
        unique case (sw_r[2:1])
            2'b00:   sel_limit = LIMIT_0;
            2'b01:   sel_limit = LIMIT_1;
            2'b10:   sel_limit = LIMIT_2;
            default: sel_limit = LIMIT_3;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_nxt    = cnt;
        period_nxt = period_q;
        enable_nxt = 1'b0;

        unique case (mode)
            MODE_RUN: begin
                // Select changes are picked up only at the wrap, so the
                // period in progress always finishes with its old length.
                // The step switch has no effect while running.
                if (at_wrap) begin
                    cnt_nxt    = '0;
                    enable_nxt = 1'b1;
                    period_nxt = sel_limit;
                end else begin
                    cnt_nxt = cnt + NB_COUNTER'(1);
                end
            end
            default: begin
                // Paused: cnt holds (pause, not clear) and the period follows
                // the select switches every cycle. A step edge fires one
                // strobe and restarts the count so the next running period
                // is a full one.
                period_nxt = sel_limit;
                if (step_rise) begin
                    cnt_nxt    = '0;
                    enable_nxt = 1'b1;
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!i_reset) begin
            cnt       <= '0;
            period_q  <= LIMIT_0;
            step_d    <= 1'b0;
            o_enable  <= 1'b0;
            o_running <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            period_q  <= period_nxt;
            step_d    <= sw_r[3];
            o_enable  <= enable_nxt;
            o_running <= sw_r[0];
        end
    end

endmodule

// File: doc/flash_tick_gen.md
# flash_tick_gen

Programmable enable-pulse generator that directly feeds the `i_enable` input of the `flash` LED-pattern block. It divides the system clock into a one-cycle strobe whose period is chosen from four build-time presets by board switches. It also supports pause and single-step from those switches. It replaces the fixed divide-by-8 stimulus used for `flash` bring-up with a board-usable source.

## Interface
- `NB_COUNTER`, 32: width of the internal cycle counter and of the period presets.
- `LIMIT_0`, 8: strobe period in clock cycles for select 00. Legal range is 2..2^NB_COUNTER-1.
- `LIMIT_1`, 16: period for select 01.
- `LIMIT_2`, 32: period for select 10.
- `LIMIT_3`, 64: period for select 11. Board builds override all four presets at instantiation.
- `clock`  in  1  system clock. All logic updates on its rising edge.
- `i_reset`  in  1  reset. Synchronous, active-low: state clears on a rising `clock` edge while `i_reset`=0.
- `i_sw`  in  4  board switches. Bit [0] is run. Bits [2:1] are period select. Bit [3] is step.
- `o_enable`  out  1  registered one-cycle strobe. Connects to `flash.i_enable`.
- `o_running`  out  1  registered copy of the effective run bit.

## Operation
- `sw_r[3:0]` is the effective switch value (see Configuration).
- Registers:
  - `cnt`, NB_COUNTER bits.
  - `period_q`, NB_COUNTER bits.
  - `step_d`, previous `sw_r[3]`.
  - `o_enable`.
  - `o_running`.
- Reset values: `cnt`=0, `period_q`=`LIMIT_0`, `step_d`=0, `o_enable`=0, `o_running`=0, synchronizer flops=0.
- Two modes, selected by `sw_r[0]`: RUN when it is 1, STOP when it is 0. `o_running` <= `sw_r[0]` every cycle.
- RUN behaviour, each cycle:
  - If `cnt` == `period_q`-1: `cnt` <= 0, `o_enable` <= 1, and `period_q` <= LIMIT[`sw_r[2:1]`].
  - Otherwise: `cnt` <= `cnt`+1 and `o_enable` <= 0.
- STOP behaviour:
  - `cnt` holds its value (pause, not clear).
  - `period_q` <= LIMIT[`sw_r[2:1]`] every cycle, so select changes apply immediately.
  - `o_enable` <= 0, except on a step.
- Step: in STOP, if `sw_r[3]`=1 and `step_d`=0, then `o_enable` <= 1 and `cnt` <= 0. `step_d` <= `sw_r[3]` every cycle.
- Step in RUN is ignored: no extra pulse, no counter effect. `step_d` still tracks `sw_r[3]`.
- A period-select change in RUN takes effect only at the next wrap. The period in progress completes with the old value.
- Clamping on select change in STOP:
  - If the new `period_q` <= the held `cnt`, the next RUN cycle treats `cnt` >= `period_q`-1 as wrap.
  - The wrap comparison is therefore `>=`, never `==` alone.
- Run removed in the same cycle `cnt` == `period_q`-1: no pulse, `cnt` holds at `period_q`-1. The first RUN edge after resume produces the pulse.
- Reset mid-count: a pending pulse is dropped. The count restarts from 0 with `period_q`=`LIMIT_0`.

## Timing
- `o_enable` is high for exactly one cycle.
- In continuous RUN, consecutive rising edges of `o_enable` are exactly `period_q` cycles apart.
- Switch-to-effect latency is 2 cycles with the synchronizer and 0 cycles without it. Register outputs add 1 cycle in both cases.
- First pulse after reset release with `i_sw`=0001 held:
  - `period_q` cycles after `sw_r[0]` first reads 1.
  - This is edge 2+8 = 10 after release with the synchronizer and `LIMIT_0`=8.
- Paused cycles do not count toward the period.
- No combinational path from `i_sw` to any output.

## Configuration
- Macro: `FLASH_TICK_GEN_SYNC_EN`.
- Defined: `i_sw` passes through a 2-flop synchronizer per bit, and `sw_r` is the second flop.
- Undefined: `sw_r` = `i_sw` directly. This is for simulation and already-synchronized sources only, and removes 2 cycles of latency.
- All other behaviour is identical in both builds.

## Test plan
- Reset and default period: hold `i_reset`=0 for 10 cycles with `i_sw`=0001.
  - During reset: `o_enable`=0 and `o_running`=0.
  - After release (macro defined): first pulse at edge 10, then one-cycle pulses every 8 cycles.
- Select change mid-period: in RUN, set `i_sw`=0111 at `cnt`=3.
  - The current period still ends 8 cycles after the previous pulse.
  - Following pulses are 64 cycles apart.
- Pause and resume: drop `i_sw[0]` at `cnt`=5 and hold for 20 cycles, then restore.
  - No pulses while paused.
  - The next pulse comes 3 running cycles after `sw_r[0]` returns to 1.
- Single step:
  - With `i_sw`=0000, raise bit 3 and hold it for 10 cycles: exactly one pulse, and `cnt` is 0.
  - Repeat with `i_sw[0]`=1: no extra pulse, and period spacing stays at 8.
- Reset mid-count: assert `i_reset`=0 at `cnt`=6 while a select-11 period is active.
  - After release: `period_q`=8, and the first pulse is at a full 8 running cycles.
- Macro off: same stimulus as the reset test, but the first pulse comes at edge 8 after release, and switch edges act on the next clock.
